// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the 4-digit seven-segment scanner.
package sevenseg_pkg;
  localparam int         N_DIGITS  = 4;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  typedef logic [1:0] slot_t;

  // Active-low anode pattern with only the given slot enabled.
  function automatic logic [3:0] anode_select_n(input slot_t slot);
    logic [3:0] onehot;
    onehot = 4'b0001 << slot;
    return ~onehot;
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// Slot-period prescaler: produces the slot-advance tick and a look-ahead
// flag saying whether the next cycle is past the anode guard interval.
module scan_prescaler #(
  parameter int DIV_BITS     = 16,
  parameter int BLANK_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick,
  output logic window_next
);
  logic [DIV_BITS-1:0] cnt;
  logic [DIV_BITS-1:0] cnt_next;

  // The counter simply freezes while the display is disabled.
  assign tick        = enable && (cnt == '1);
  assign cnt_next    = enable ? cnt + DIV_BITS'(1) : cnt;
  assign window_next = enable && (cnt_next >= DIV_BITS'(BLANK_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end
endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed, double-buffered scanner for a 4-digit common-anode display.
// All outputs are flops fed from next-state values so they move with cnt/sel.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int DIV_BITS     = 16,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        enable,
  output logic [3:0]  digit,
  output logic [3:0]  anode_n,
  output logic        dp_n,
  output logic        frame_start
);
  logic        tick;
  logic        window_next;
  slot_t       sel, sel_next;
  logic [15:0] pend, pend_next;
  logic [15:0] disp, disp_next;
  logic [3:0]  pend_dp, pend_dp_next;
  logic [3:0]  disp_dp, disp_dp_next;
  logic        pend_v, pend_v_next;
  logic        boundary;
  logic        suppressed;
  logic        lit;
  logic [15:0] upper_digits;

  scan_prescaler #(
    .DIV_BITS    (DIV_BITS),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_prescaler (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .tick       (tick),
    .window_next(window_next)
  );

  always_comb begin
    sel_next     = tick ? sel + 2'd1 : sel;
    boundary     = tick && (sel == slot_t'(N_DIGITS - 1));
    disp_next    = disp;
    disp_dp_next = disp_dp;
    pend_next    = pend;
    pend_dp_next = pend_dp;
    pend_v_next  = pend_v;
    // Transfer uses the pending value from before any coincident load.
    if (boundary && pend_v) begin
      disp_next    = pend;
      disp_dp_next = pend_dp;
      pend_v_next  = 1'b0;
    end
    if (load) begin
      pend_next    = value_in;
      pend_dp_next = dp_in;
      pend_v_next  = 1'b1;
    end
    upper_digits = disp_next >> {sel_next, 2'b00};
    suppressed   = blank_lz && (sel_next != 2'd0) && (upper_digits == 16'h0000);
    lit          = window_next && !suppressed;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel         <= '0;
      pend        <= '0;
      pend_dp     <= '0;
      pend_v      <= 1'b0;
      disp        <= '0;
      disp_dp     <= '0;
      digit       <= '0;
      anode_n     <= ANODE_OFF;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      sel         <= sel_next;
      pend        <= pend_next;
      pend_dp     <= pend_dp_next;
      pend_v      <= pend_v_next;
      disp        <= disp_next;
      disp_dp     <= disp_dp_next;
      digit       <= disp_next[{sel_next, 2'b00} +: 4];
      anode_n     <= lit ? anode_select_n(sel_next) : ANODE_OFF;
      dp_n        <= lit ? ~disp_dp_next[sel_next] : 1'b1;
      frame_start <= boundary;
    end
  end
endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed plus randomized bench for sevenseg_scan with a position-based
// reference model (position = enabled clocks since reset, modulo one frame).
module tb_sevenseg_scan;
  localparam int DIV_BITS = 4;
  localparam int BLANK    = 2;
  localparam int SLOT     = 1 << DIV_BITS;
  localparam int FRAME    = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic        enable;
  logic [3:0]  digit;
  logic [3:0]  anode_n;
  logic        dp_n;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_pos;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  bit          m_pv;

  logic [9:0] exp_q[$];

  sevenseg_scan #(.DIV_BITS(DIV_BITS), .BLANK_CYCLES(BLANK)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .enable     (enable),
    .digit      (digit),
    .anode_n    (anode_n),
    .dp_n       (dp_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pos  = 0;
    m_disp = '0;
    m_pend = '0;
    m_ddp  = '0;
    m_pdp  = '0;
    m_pv   = 1'b0;
  endtask

  // Expected {frame_start, dp_n, anode_n, digit} from the current model position.
  function automatic logic [9:0] model_expect(input bit fs);
    int          cnt, sel;
    logic [15:0] upper;
    logic [3:0]  an, dg;
    bit          supp, lit, dpn;
    cnt   = m_pos % SLOT;
    sel   = m_pos / SLOT;
    dg    = m_disp[4*sel +: 4];
    upper = m_disp >> (4 * sel);
    supp  = blank_lz && (sel > 0) && (upper == 16'h0);
    lit   = enable && (cnt >= BLANK) && !supp;
    an    = 4'hF;
    dpn   = 1'b1;
    if (lit) begin
      an[sel] = 1'b0;
      dpn     = !m_ddp[sel];
    end
    return {fs, dpn, an, dg};
  endfunction

  task automatic compare(input string tag);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed none expected entry", tag);
      return;
    end
    e = exp_q.pop_front();
    n_checks++;
    assert (digit === e[3:0]) else begin
      n_fail++;
      $error("FAIL %s.digit pos=%0d: observed %h expected %h", tag, m_pos, digit, e[3:0]);
    end
    n_checks++;
    assert (anode_n === e[7:4]) else begin
      n_fail++;
      $error("FAIL %s.anode_n pos=%0d: observed %b expected %b", tag, m_pos, anode_n, e[7:4]);
    end
    n_checks++;
    assert (dp_n === e[8]) else begin
      n_fail++;
      $error("FAIL %s.dp_n pos=%0d: observed %b expected %b", tag, m_pos, dp_n, e[8]);
    end
    n_checks++;
    assert (frame_start === e[9]) else begin
      n_fail++;
      $error("FAIL %s.frame_start pos=%0d: observed %b expected %b", tag, m_pos, frame_start, e[9]);
    end
  endtask

  // Driver: apply inputs for one clock, advance the model, check after the edge.
  task automatic step(input bit en, input bit ld, input logic [15:0] v, input logic [3:0] dp);
    bit boundary;
    enable   = en;
    load     = ld;
    value_in = v;
    dp_in    = dp;
    @(posedge clk);
    boundary = en && (m_pos == FRAME - 1);
    if (boundary && m_pv) begin
      m_disp = m_pend;
      m_ddp  = m_pdp;
      m_pv   = 1'b0;
    end
    if (ld) begin
      m_pend = v;
      m_pdp  = dp;
      m_pv   = 1'b1;
    end
    if (en) m_pos = (m_pos + 1) % FRAME;
    exp_q.push_back(model_expect(boundary));
    #1;
    compare("step");
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  // Advance with enable high until the model reaches target position.
  task automatic run_to(input int target);
    int guard_cnt;
    guard_cnt = 0;
    while (m_pos != target && guard_cnt < 2 * FRAME) begin
      step(1'b1, 1'b0, 16'h0, 4'h0);
      guard_cnt++;
    end
    n_checks++;
    assert (m_pos == target) else begin
      n_fail++;
      $error("FAIL run_to: observed pos %0d expected %0d", m_pos, target);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    value_in = '0;
    dp_in    = '0;
    load     = 1'b0;
    blank_lz = 1'b0;
    enable   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(model_expect(1'b0));
    compare("reset");
    reset_n = 1'b1;

    // Blank display, guard, and first frame_start after one full frame
    idle(FRAME + 6);

    // Load during slot 1: current frame untouched, next frame shows 12AB
    run_to(SLOT + 4);
    step(1'b1, 1'b1, 16'h12AB, 4'b0100);
    idle(2 * FRAME);

    // Leading-zero suppression
    blank_lz = 1'b1;
    step(1'b1, 1'b1, 16'h0050, 4'b1111);
    idle(2 * FRAME);
    step(1'b1, 1'b1, 16'h0000, 4'b0000);
    idle(2 * FRAME);
    blank_lz = 1'b0;

    // Last write wins, then load coincident with a boundary while pending
    run_to(8);
    step(1'b1, 1'b1, 16'h1111, 4'h0);
    step(1'b1, 1'b1, 16'h2222, 4'h0);
    run_to(FRAME - 1);
    step(1'b1, 1'b1, 16'h3333, 4'h1);
    idle(2 * FRAME);

    // Boundary load with nothing pending: shows up one frame later
    run_to(FRAME - 1);
    step(1'b1, 1'b1, 16'h4567, 4'h8);
    idle(2 * FRAME);

    // Disable mid-slot: dark and frozen, then resume
    run_to(2 * SLOT + 5);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
    idle(SLOT);

    // Async reset mid-slot with a pending value
    step(1'b1, 1'b1, 16'hABCD, 4'hF);
    idle(3);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(model_expect(1'b0));
    compare("async_reset");
    @(posedge clk);
    #1;
    exp_q.push_back(model_expect(1'b0));
    compare("reset_hold");
    reset_n = 1'b1;
    idle(2 * FRAME + 4);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
           16'($urandom), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end
endmodule
